// File: rtl/lcd_read_ctrl.sv
// HD44780 read-cycle controller: busy-flag/address reads, data reads and BF auto-poll.
// Optional macro LCD_READ_TIMEOUT_EN bounds auto-poll to MAX_POLLS reads and adds a timeout pulse.
module lcd_read_ctrl #(
  parameter int unsigned T_AS = 4,
  parameter int unsigned T_EH = 24,
  parameter int unsigned T_EL = 24
`ifdef LCD_READ_TIMEOUT_EN
  , parameter logic [15:0] MAX_POLLS = 16'd1000
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic       req_rs,
  input  logic       req_poll,
  output logic       ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic [6:0] addr_cnt,
  output logic       owns_bus,
  output logic       lcd_RS,
  output logic       lcd_RW,
  output logic       lcd_E,
`ifdef LCD_READ_TIMEOUT_EN
  output logic       timeout,
`endif
  input  logic [7:0] lcd_data_in
);

  localparam logic [7:0] LD_AS = 8'(T_AS - 1);
  localparam logic [7:0] LD_EH = 8'(T_EH - 1);
  localparam logic [7:0] LD_EL = 8'(T_EL - 1);

  typedef enum logic [2:0] {IDLE, SETUP, EHIGH, ELOW, DONE} state_t;
  typedef struct packed {
    logic rs;
    logic poll;
  } rd_req_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  rd_req_t    req_l, req_n;
  logic       sample, repoll, to_hit;
`ifdef LCD_READ_TIMEOUT_EN
  logic [15:0] poll_cnt;
`endif

  // busy_flag already holds this round's sample by DONE (T_EL >= 1)
  assign repoll = req_l.poll & busy_flag;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = req_l;
    sample  = 1'b0;
    to_hit  = 1'b0;
    case (state)
      IDLE: if (req) begin
        state_n    = SETUP;
        cnt_n      = LD_AS;
        req_n.rs   = req_rs & ~req_poll;
        req_n.poll = req_poll;
      end
      SETUP: if (cnt == 8'd0) begin
        state_n = EHIGH;
        cnt_n   = LD_EH;
      end else cnt_n = cnt - 8'd1;
      EHIGH: if (cnt == 8'd0) begin
        state_n = ELOW;
        cnt_n   = LD_EL;
        sample  = 1'b1;
      end else cnt_n = cnt - 8'd1;
      ELOW: if (cnt == 8'd0) state_n = DONE;
            else cnt_n = cnt - 8'd1;
      DONE: if (repoll) begin
`ifdef LCD_READ_TIMEOUT_EN
        if (poll_cnt == MAX_POLLS - 16'd1) begin
          state_n = IDLE;
          to_hit  = 1'b1;
        end else
`endif
        begin
          state_n = SETUP;
          cnt_n   = LD_AS;
        end
      end else state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bus pins are registered off the next state so they switch cleanly on the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      req_l     <= '0;
      ready     <= 1'b1;
      owns_bus  <= 1'b0;
      lcd_RS    <= 1'b0;
      lcd_RW    <= 1'b0;
      lcd_E     <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 8'd0;
      busy_flag <= 1'b0;
      addr_cnt  <= 7'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      req_l    <= req_n;
      ready    <= (state_n == IDLE);
      owns_bus <= (state_n != IDLE);
      lcd_RW   <= (state_n != IDLE);
      lcd_RS   <= (state_n != IDLE) & req_n.rs;
      lcd_E    <= (state_n == EHIGH);
      rd_valid <= (state_n == DONE) & ~repoll;
      if (sample) begin
        rd_data <= lcd_data_in;
        if (!req_l.rs) {busy_flag, addr_cnt} <= lcd_data_in;
      end
    end
  end

`ifdef LCD_READ_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= 16'd0;
      timeout  <= 1'b0;
    end else begin
      timeout <= to_hit;
      if (state == IDLE && req) poll_cnt <= 16'd0;
      else if (state == DONE && repoll) poll_cnt <= poll_cnt + 16'd1;
    end
  end
`else
  logic unused_to;
  assign unused_to = to_hit;
`endif

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Bench for lcd_read_ctrl: timeline model of expected bus waveforms plus directed read scenarios.
module tb_lcd_read_ctrl;
  localparam int T_AS = 4, T_EH = 24, T_EL = 24;
  localparam int P = T_AS + T_EH + T_EL + 1;
`ifdef LCD_READ_TIMEOUT_EN
  localparam int MAXP = 5;
`endif

  logic clk = 1'b0, reset_n = 1'b1;
  logic req = 1'b0, req_rs = 1'b0, req_poll = 1'b0;
  logic ready, rd_valid, busy_flag, owns_bus, lcd_RS, lcd_RW, lcd_E;
  logic [7:0] rd_data;
  logic [6:0] addr_cnt;
  logic [7:0] lcd_data_in = 8'h00;
`ifdef LCD_READ_TIMEOUT_EN
  logic timeout;
`endif

  lcd_read_ctrl #(
    .T_AS(T_AS), .T_EH(T_EH), .T_EL(T_EL)
`ifdef LCD_READ_TIMEOUT_EN
    , .MAX_POLLS(16'(MAXP))
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_rs(req_rs), .req_poll(req_poll),
    .ready(ready), .rd_valid(rd_valid), .rd_data(rd_data), .busy_flag(busy_flag),
    .addr_cnt(addr_cnt), .owns_bus(owns_bus), .lcd_RS(lcd_RS), .lcd_RW(lcd_RW),
    .lcd_E(lcd_E),
`ifdef LCD_READ_TIMEOUT_EN
    .timeout(timeout),
`endif
    .lcd_data_in(lcd_data_in)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // LCD panel: presents the next scripted byte each time E rises within one bus ownership
  logic [7:0] resp [16];
  int ecnt = 0;
  always @(posedge lcd_E or negedge owns_bus) begin
    if (!owns_bus) ecnt = 0;
    else begin
      lcd_data_in = resp[ecnt];
      if (ecnt < 15) ecnt++;
    end
  end

  // Timeline model: an access is n read rounds of P cycles each, counted from the accept edge
  int cyc = 0, k = 0, n = 0, off_m;
  logic m_busy = 1'b0, m_rs = 1'b0, m_fv = 1'b0, m_to_pend = 1'b0, m_to = 1'b0;
  logic [7:0] e_data = 8'h00;
  logic e_bf = 1'b0;
  logic [6:0] e_ac = 7'h00;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_to = 1'b0;
      e_data = 8'h00; e_bf = 1'b0; e_ac = 7'h00;
    end else begin
      cyc++;
      m_to = 1'b0;
      if (m_busy) begin
        off_m = cyc - k;
        if (off_m == n * P) begin
          m_busy = 1'b0;
          m_to   = m_to_pend;
        end else if (off_m % P == T_AS + T_EH) begin
          e_data = resp[off_m / P];
          if (!m_rs) {e_bf, e_ac} = resp[off_m / P];
        end
      end else if (req) begin
        m_busy = 1'b1; k = cyc;
        m_rs = req_rs & ~req_poll;
        n = 1; m_fv = 1'b1; m_to_pend = 1'b0;
        if (req_poll) begin
          n = 0;
          for (int j = 0; j < 16; j++) if (n == 0 && !resp[j][7]) n = j + 1;
`ifdef LCD_READ_TIMEOUT_EN
          if (n == 0 || n > MAXP) begin n = MAXP; m_fv = 1'b0; m_to_pend = 1'b1; end
`endif
        end
      end
    end
  end

  int off_c, o_c, j_c;
  logic [5:0] exp_ctrl;
  always @(negedge clk) begin
    if (m_busy) begin
      off_c = cyc - k; o_c = off_c % P; j_c = off_c / P;
      exp_ctrl = {1'b1, 1'b1, m_rs, (o_c >= T_AS && o_c < T_AS + T_EH), 1'b0,
                  (o_c == P - 1 && j_c == n - 1 && m_fv)};
    end else exp_ctrl = 6'b000010;
    chk("ctrl{owns,rw,rs,e,ready,valid}",
        32'({owns_bus, lcd_RW, lcd_RS, lcd_E, ready, rd_valid}), 32'(exp_ctrl));
    chk("rdata{data,bf,ac}", 32'({rd_data, busy_flag, addr_cnt}), 32'({e_data, e_bf, e_ac}));
`ifdef LCD_READ_TIMEOUT_EN
    chk("timeout", 32'(timeout), 32'(m_to));
`endif
  end

  int rv_count = 0, e_rises = 0, e_cycles = 0, to_count = 0;
  int rv_cyc = 0, e_rise_cyc = 0, rw_rise_cyc = 0;
  logic e_prev = 1'b0, rw_prev = 1'b0;
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin rv_count++; rv_cyc = cyc; end
    if (lcd_E === 1'b1) e_cycles++;
    if (lcd_E === 1'b1 && !e_prev) begin e_rises++; e_rise_cyc = cyc; end
    if (lcd_RW === 1'b1 && !rw_prev) rw_rise_cyc = cyc;
`ifdef LCD_READ_TIMEOUT_EN
    if (timeout === 1'b1) to_count++;
`endif
    e_prev = (lcd_E === 1'b1);
    rw_prev = (lcd_RW === 1'b1);
  end

  task automatic do_req(input logic rs, input logic poll, output int acc);
    @(posedge clk); #1 req = 1'b1; req_rs = rs; req_poll = poll;
    @(posedge clk); #1 req = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_idle(input string nm);
    logic ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ready === 1'b1 && !m_busy) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    chk(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, rv0, er0, ec0;
    logic ok;
    for (int i = 0; i < 16; i++) resp[i] = 8'h00;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_owns", 32'({owns_bus, lcd_RW, lcd_E}), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    reset_n = 1'b1;

    // data read: timing pinned against the accept edge
    resp[0] = 8'h41; rv0 = rv_count; er0 = e_rises; ec0 = e_cycles;
    do_req(1'b1, 1'b0, a0); wait_idle("t1_idle");
    chk("t1_rw_rise", 32'(rw_rise_cyc - a0), 32'd0);
    chk("t1_e_rise", 32'(e_rise_cyc - a0), 32'd4);
    chk("t1_e_width", 32'(e_cycles - ec0), 32'd24);
    chk("t1_latency", 32'(rv_cyc - a0), 32'd52);
    chk("t1_valids", 32'(rv_count - rv0), 32'd1);
    chk("t1_data", 32'({rd_data, busy_flag, addr_cnt}), 32'({8'h41, 1'b0, 7'h00}));

    // busy-flag/address read
    resp[0] = 8'h85; rv0 = rv_count;
    do_req(1'b0, 1'b0, a0); wait_idle("t2_idle");
    chk("t2_valids", 32'(rv_count - rv0), 32'd1);
    chk("t2_data", 32'({rd_data, busy_flag, addr_cnt}), 32'({8'h85, 1'b1, 7'h05}));

    // data read leaves BF/AC alone
    resp[0] = 8'h33;
    do_req(1'b1, 1'b0, a0); wait_idle("t2b_idle");
    chk("t2b_data", 32'({rd_data, busy_flag, addr_cnt}), 32'({8'h33, 1'b1, 7'h05}));

    // poll: three busy reads then clear
    resp[0] = 8'h80; resp[1] = 8'h80; resp[2] = 8'h80; resp[3] = 8'h12;
    rv0 = rv_count; er0 = e_rises; ec0 = e_cycles;
    do_req(1'b0, 1'b1, a0); wait_idle("t3_idle");
    chk("t3_e_pulses", 32'(e_rises - er0), 32'd4);
    chk("t3_e_cycles", 32'(e_cycles - ec0), 32'd96);
    chk("t3_valids", 32'(rv_count - rv0), 32'd1);
    chk("t3_data", 32'({rd_data, busy_flag, addr_cnt}), 32'({8'h12, 1'b0, 7'h12}));

    // poll forces RS=0 even with req_rs=1; clear on the first read
    resp[0] = 8'h07; er0 = e_rises;
    do_req(1'b1, 1'b1, a0); wait_idle("t4_idle");
    chk("t4_e_pulses", 32'(e_rises - er0), 32'd1);
    chk("t4_data", 32'({rd_data, busy_flag, addr_cnt}), 32'({8'h07, 1'b0, 7'h07}));

    // reset in the middle of EHIGH
    resp[0] = 8'h5A;
    do_req(1'b1, 1'b0, a0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (lcd_E === 1'b1) begin ok = 1'b1; break; end end
    chk("t5_e_high", 32'(ok), 32'd1);
    @(posedge clk); repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("t5_async_cut", 32'({lcd_E, lcd_RW, owns_bus}), 32'd0);
    @(posedge clk); #1;
    chk("t5_rst_ready", 32'(ready), 32'd1);
    reset_n = 1'b1;
    rv0 = rv_count;
    do_req(1'b1, 1'b0, a0); wait_idle("t5_idle");
    chk("t5_valids", 32'(rv_count - rv0), 32'd1);
    chk("t5_data", 32'(rd_data), 32'h5A);

    // req pulses during SETUP and ELOW are dropped
    resp[0] = 8'h66; rv0 = rv_count;
    do_req(1'b1, 1'b0, a0);
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    repeat (35) @(posedge clk);
    #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    wait_idle("t6_idle");
    repeat (3) @(posedge clk);
    #1 chk("t6_valids", 32'(rv_count - rv0), 32'd1);
    chk("t6_data", 32'(rd_data), 32'h66);

`ifdef LCD_READ_TIMEOUT_EN
    begin
      int to0;
      for (int i = 0; i < 16; i++) resp[i] = 8'h80;
      rv0 = rv_count; er0 = e_rises; to0 = to_count;
      do_req(1'b0, 1'b1, a0); wait_idle("t7_idle");
      chk("t7_e_pulses", 32'(e_rises - er0), 32'd5);
      chk("t7_timeouts", 32'(to_count - to0), 32'd1);
      chk("t7_valids", 32'(rv_count - rv0), 32'd0);
      chk("t7_ready", 32'(ready), 32'd1);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
